// File: rtl/life_scheduler.sv
// Memory-ownership sequencer for the life display: hands the cell memory to the update
// engine during vertical blanking when a generation or clear is pending.
module life_scheduler #(
   parameter int unsigned FRAMES_PER_GEN = 30,
   parameter int unsigned GEN_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic                 blank_end,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_code,
   output logic                 cmd_ready,
   output logic                 step_start,
   input  logic                 step_done,
   output logic                 clear_start,
   input  logic                 clear_done,
   output logic                 mem_owner,
   output logic                 display_enable,
   output logic                 running,
   output logic [GEN_WIDTH-1:0] gen_count,
   output logic                 error
);

   typedef enum logic [2:0] {StIdle, StHandover, StStep, StClear, StRelease} state_t;

   localparam logic [15:0] TermCount = 16'(FRAMES_PER_GEN - 1);

   state_t               state_q, state_d;
   logic [15:0]          frame_q, frame_d;
   logic [GEN_WIDTH-1:0] gen_q, gen_d;
   logic                 step_pend_q, step_pend_d;
   logic                 clear_pend_q, clear_pend_d;
   logic                 do_clear_q, do_clear_d;
   logic                 running_q, running_d;
   logic                 error_q, error_d;
   logic                 mem_owner_q, display_q, step_start_q, clear_start_q, cmd_ready_q;
   logic                 cmd_acc, tc;

   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      gen_d        = gen_q;
      step_pend_d  = step_pend_q;
      clear_pend_d = clear_pend_q;
      do_clear_d   = do_clear_q;
      running_d    = running_q;
      error_d      = error_q;
      cmd_acc      = cmd_valid && cmd_ready_q;
      tc           = running_q && frame_start && (frame_q == TermCount);

      unique case (state_q)
         StIdle: begin
            // A terminal-count frame is serviced by that very frame_start.
            if (frame_start && (clear_pend_q || step_pend_q || tc)) begin
               state_d    = StHandover;
               do_clear_d = clear_pend_q;
            end
         end
         StHandover: begin
            if (do_clear_q) begin
               clear_pend_d = 1'b0;
               state_d      = StClear;
            end else begin
               step_pend_d = 1'b0;
               state_d     = StStep;
            end
         end
         StStep: begin
            if (step_done) begin
               gen_d   = gen_q + GEN_WIDTH'(1);
               state_d = StRelease;
            end
         end
         StClear: begin
            if (clear_done) begin
               gen_d   = '0;
               state_d = StRelease;
            end
         end
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase

      if (running_q && frame_start) begin
         frame_d = tc ? 16'd0 : frame_q + 16'd1;
         if (tc) step_pend_d = 1'b1;
      end

      if (cmd_acc) begin
         unique case (cmd_code)
            2'b00: running_d = 1'b0;
            2'b01: begin
               running_d = 1'b1;
               frame_d   = 16'd0;
            end
            2'b10: step_pend_d  = 1'b1;
            2'b11: clear_pend_d = 1'b1;
            default: ;
         endcase
      end

      if (state_q == StClear && clear_done) begin
         step_pend_d = 1'b0;
         frame_d     = 16'd0;
      end

      if ((blank_end && (state_q == StStep || state_q == StClear)) ||
          (step_done && state_q != StStep) || (clear_done && state_q != StClear)) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         frame_q       <= '0;
         gen_q         <= '0;
         step_pend_q   <= 1'b0;
         clear_pend_q  <= 1'b0;
         do_clear_q    <= 1'b0;
         running_q     <= 1'b0;
         error_q       <= 1'b0;
         mem_owner_q   <= 1'b0;
         display_q     <= 1'b1;
         step_start_q  <= 1'b0;
         clear_start_q <= 1'b0;
         cmd_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         frame_q       <= frame_d;
         gen_q         <= gen_d;
         step_pend_q   <= step_pend_d;
         clear_pend_q  <= clear_pend_d;
         do_clear_q    <= do_clear_d;
         running_q     <= running_d;
         error_q       <= error_d;
         mem_owner_q   <= (state_d != StIdle);
         display_q     <= (state_d == StIdle);
         step_start_q  <= (state_q == StHandover) && !do_clear_q;
         clear_start_q <= (state_q == StHandover) && do_clear_q;
         cmd_ready_q   <= (state_d == StIdle) && !step_pend_d && !clear_pend_d;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign step_start     = step_start_q;
   assign clear_start    = clear_start_q;
   assign mem_owner      = mem_owner_q;
   assign display_enable = display_q;
   assign running        = running_q;
   assign gen_count      = gen_q;
   assign error          = error_q;

endmodule

// File: tb/tb_life_scheduler.sv
// Self-checking bench for life_scheduler: cycle vector table, hand-written corner sequences
// and randomized frame/command traffic checked against a frame-level model.
module tb_life_scheduler;

   localparam int unsigned Fpg = 3;
   localparam int unsigned Gw  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          frame_start = 1'b0, blank_end = 1'b0, cmd_valid = 1'b0;
   logic [1:0]    cmd_code = 2'b00;
   logic          step_done = 1'b0, clear_done = 1'b0;
   logic          cmd_ready, step_start, clear_start, mem_owner, display_enable, running, error;
   logic [Gw-1:0] gen_count;

   int checks = 0;
   int errors = 0;

   // Frame-level reference model state
   int  m_gen, m_fc;
   bit  m_run, m_sp, m_cp;
   int  n_steps;

   life_scheduler #(.FRAMES_PER_GEN(Fpg), .GEN_WIDTH(Gw)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .blank_end(blank_end),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
      .step_start(step_start), .step_done(step_done), .clear_start(clear_start),
      .clear_done(clear_done), .mem_owner(mem_owner), .display_enable(display_enable),
      .running(running), .gen_count(gen_count), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       fs, be, cv;
      logic [1:0] cc;
      logic       sd, cd;
      logic       mo, de, ss, cs, rdy;
      logic [3:0] gen;
      logic       err;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      frame_start = 0; blank_end = 0; cmd_valid = 0; step_done = 0; clear_done = 0;
      reset = 0;
      repeat (3) tick();
      reset = 1;
      m_gen = 0; m_fc = 0; m_run = 0; m_sp = 0; m_cp = 0;
   endtask

   task automatic issue_cmd(input logic [1:0] code);
      check("cmd_ready", int'(cmd_ready), int'(!m_sp && !m_cp));
      if (!m_sp && !m_cp) begin
         cmd_valid = 1; cmd_code = code;
         tick();
         cmd_valid = 0;
         case (code)
            2'b00: m_run = 0;
            2'b01: begin m_run = 1; m_fc = 0; end
            2'b10: m_sp = 1;
            default: m_cp = 1;
         endcase
      end
   endtask

   // One frame with the scheduler idle; engine answers dly cycles after its start pulse.
   task automatic do_frame(input int dly);
      int exp_kind, got;
      bit tcount;
      tcount = m_run && (m_fc == Fpg - 1);
      if (m_run) m_fc = tcount ? 0 : m_fc + 1;
      if (tcount) m_sp = 1;
      if (m_cp) begin
         exp_kind = 2; m_cp = 0; m_sp = 0; m_fc = 0; m_gen = 0;
      end else if (m_sp) begin
         exp_kind = 1; m_sp = 0; m_gen = (m_gen + 1) % (1 << Gw);
      end else begin
         exp_kind = 0;
      end
      frame_start = 1;
      tick();
      frame_start = 0;
      got = 0;
      for (int i = 0; i < 6; i++) begin
         if (step_start) got = 1;
         else if (clear_start) got = 2;
         if (got != 0) break;
         tick();
      end
      check("start_kind", got, exp_kind);
      if (got != 0) begin
         if (got == 1) n_steps++;
         repeat (dly) tick();
         if (got == 1) step_done = 1; else clear_done = 1;
         tick();
         step_done = 0; clear_done = 0;
         tick();
         check("release_owner", int'(mem_owner), 0);
      end
      check("gen_count", int'(gen_count), m_gen);
      check("ready_after_frame", int'(cmd_ready), int'(!m_sp && !m_cp));
   endtask

   task automatic wait_step_start(output bit ok);
      ok = 0;
      for (int i = 0; i < 8; i++) begin
         if (step_start) begin ok = 1; break; end
         tick();
      end
      if (!ok) check("step_start_timeout", 0, 1);
   endtask

   initial begin
      bit ok;
      logic [10:0] act_v, exp_v;

      //          fs be cv cc   sd cd  mo de ss cs rdy gen  err
      tbl[0] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1};

      // Reset values
      do_reset();
      check("rst_mem_owner", int'(mem_owner), 0);
      check("rst_display_enable", int'(display_enable), 1);
      check("rst_gen_count", int'(gen_count), 0);
      check("rst_running", int'(running), 0);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_error", int'(error), 0);
      check("rst_starts", int'({step_start, clear_start}), 0);

      // Single step, then stray pulses
      for (int i = 0; i < 10; i++) begin
         frame_start = tbl[i].fs; blank_end = tbl[i].be; cmd_valid = tbl[i].cv;
         cmd_code = tbl[i].cc; step_done = tbl[i].sd; clear_done = tbl[i].cd;
         tick();
         act_v = {mem_owner, display_enable, step_start, clear_start, cmd_ready, gen_count, error};
         exp_v = {tbl[i].mo, tbl[i].de, tbl[i].ss, tbl[i].cs, tbl[i].rdy, tbl[i].gen, tbl[i].err};
         check($sformatf("vec%0d", i), int'(act_v), int'(exp_v));
      end
      frame_start = 0; step_done = 0; clear_done = 0; cmd_valid = 0;

      // Run mode: 9 frames -> 3 steps
      do_reset();
      n_steps = 0;
      issue_cmd(2'b01);
      check("running", int'(running), 1);
      for (int i = 0; i < 9; i++) do_frame(5);
      check("run_step_count", n_steps, 3);
      check("run_gen_count", int'(gen_count), 3);
      issue_cmd(2'b00);

      // Clear wins over a coincident step; the step is dropped
      issue_cmd(2'b01);
      do_frame(3);
      do_frame(3);
      issue_cmd(2'b11);
      n_steps = 0;
      do_frame(4);
      do_frame(4);
      check("no_step_after_clear", n_steps, 0);
      check("gen_after_clear", int'(gen_count), 0);
      issue_cmd(2'b00);
      check("error_clean", int'(error), 0);

      // Overrun: blank_end during STEP
      do_reset();
      issue_cmd(2'b10);
      frame_start = 1; tick(); frame_start = 0;
      wait_step_start(ok);
      blank_end = 1; tick(); blank_end = 0;
      check("overrun_error", int'(error), 1);
      repeat (3) tick();
      check("overrun_de_held", int'(display_enable), 0);
      check("overrun_owner_held", int'(mem_owner), 1);
      step_done = 1; tick(); step_done = 0;
      check("overrun_de_d1", int'(display_enable), 0);
      tick();
      check("overrun_de_d2", int'(display_enable), 1);
      check("overrun_error_sticky", int'(error), 1);

      // Generation counter wrap
      do_reset();
      for (int i = 0; i < 16; i++) begin
         issue_cmd(2'b10);
         do_frame(1);
      end
      check("gen_wrap", int'(gen_count), 0);

      // Reset while the engine owns memory
      issue_cmd(2'b10);
      frame_start = 1; tick(); frame_start = 0;
      wait_step_start(ok);
      tick();
      check("pre_reset_owner", int'(mem_owner), 1);
      reset = 0; tick(); reset = 1;
      check("midreset_owner", int'(mem_owner), 0);
      check("midreset_de", int'(display_enable), 1);
      check("midreset_ready", int'(cmd_ready), 1);
      m_gen = 0; m_fc = 0; m_run = 0; m_sp = 0; m_cp = 0;

      // Randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) issue_cmd(2'($urandom_range(0, 3)));
         do_frame(int'($urandom_range(1, 6)));
      end
      check("rand_error", int'(error), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
